// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU datapath types and constants for the MDR slice
package cpu_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int MDR_BUS_IDX    = 21;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } mdrState_t;

endpackage

// File: rtl/mdr_timeout_counter.sv
// rtl/mdr_timeout_counter.sv - consecutive wait-state counter, used only with MDR_TIMEOUT_EN
module mdr_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  // Restarts at zero on every pass through IDLE, so each transfer gets a full budget.
  always_ff @(posedge clk) begin
    if (clear || !run) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign expired = run && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mdr_unit.sv
// rtl/mdr_unit.sv - memory data register with read/write handshake; MDR_TIMEOUT_EN adds wait-state abort
module mdr_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W         = DEFAULT_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MDRin,
  input  logic              rd_start,
  input  logic              wr_start,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] BusMuxIn_MDR,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  mdrState_t         state, nextState;
  logic [DATA_W-1:0] mdr;
  logic              loadBus, loadRead, doneNext, abort, accept, expired;

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
      mdr   <= '0;
      done  <= 1'b0;
    end else begin
      state <= nextState;
      done  <= doneNext;
      if (loadRead) begin
        mdr <= mem_rdata;
      end else if (loadBus) begin
        mdr <= BusMuxOut;
      end
    end
  end

  // Ack beats expiry so a late-but-valid completion is never thrown away.
  always_comb begin
    nextState = state;
    loadBus   = 1'b0;
    loadRead  = 1'b0;
    doneNext  = 1'b0;
    abort     = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (rd_start) begin
          nextState = RD_WAIT;
          accept    = 1'b1;
        end else if (wr_start) begin
          nextState = WR_WAIT;
          accept    = 1'b1;
        end else if (MDRin) begin
          loadBus = 1'b1;
        end
      end
      RD_WAIT: begin
        if (mem_ack) begin
          nextState = IDLE;
          loadRead  = 1'b1;
          doneNext  = 1'b1;
        end else if (expired) begin
          nextState = IDLE;
          abort     = 1'b1;
        end
      end
      WR_WAIT: begin
        if (mem_ack) begin
          nextState = IDLE;
          doneNext  = 1'b1;
        end else if (expired) begin
          nextState = IDLE;
          abort     = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign mem_rd_req   = (state == RD_WAIT);
  assign mem_wr_req   = (state == WR_WAIT);
  assign busy         = (state != IDLE);
  assign mem_wdata    = mdr;
  assign BusMuxIn_MDR = mdr;

`ifdef MDR_TIMEOUT_EN
  logic timeoutErr;

  mdr_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) uTimeout (
    .clk    (clk),
    .clear  (clear),
    .run    (busy),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (clear || accept) begin
      timeoutErr <= 1'b0;
    end else if (abort) begin
      timeoutErr <= 1'b1;
    end
  end

  assign timeout_err = timeoutErr;
`else
  logic unusedCfg;

  assign expired     = 1'b0;
  assign timeout_err = 1'b0;
  assign unusedCfg   = (TIMEOUT_CYCLES != 0) ^ abort ^ accept;
`endif

endmodule

// File: tb/tb_mdr_unit.sv
// tb/tb_mdr_unit.sv - scoreboard bench for mdr_unit; timeout cases need MDR_TIMEOUT_EN
module tb_mdr_unit;

  logic        clk = 1'b0;
  logic        clear, MDRin, rd_start, wr_start, mem_ack;
  logic [31:0] BusMuxOut, mem_rdata;
  logic        mem_rd_req, mem_wr_req, busy, done, timeout_err;
  logic [31:0] mem_wdata, BusMuxIn_MDR;

  int tests = 0;
  int fails = 0;
  logic [31:0] expQ[$];
  logic [31:0] expVal;

  always #5 clk = ~clk;

  mdr_unit #(.DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .clear(clear), .BusMuxOut(BusMuxOut), .MDRin(MDRin),
    .rd_start(rd_start), .wr_start(wr_start),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
    .BusMuxIn_MDR(BusMuxIn_MDR), .busy(busy), .done(done),
    .timeout_err(timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadMdr(input logic [31:0] v);
    MDRin = 1'b1; BusMuxOut = v;
    tick();
    MDRin = 1'b0; BusMuxOut = '0;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tests++;
    if ({busy, done, mem_rd_req, mem_wr_req, timeout_err} !== 5'b0 || BusMuxIn_MDR !== 32'h0) begin
      fails++;
      $display("FAIL reset: flags=%b mdr=%h required flags=00000 mdr=00000000",
               {busy, done, mem_rd_req, mem_wr_req, timeout_err}, BusMuxIn_MDR);
    end
  endtask

  task automatic test_load();
    loadMdr(32'hDEADBEEF);
    tests++;
    if (BusMuxIn_MDR !== 32'hDEADBEEF || busy !== 1'b0) begin
      fails++;
      $display("FAIL load: mdr=%h busy=%b required mdr=deadbeef busy=0", BusMuxIn_MDR, busy);
    end
  endtask

  task automatic test_read();
    int rdCount = 0;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    expQ.push_back(32'h12345678);
    for (int i = 0; i < 3; i++) begin
      if (mem_rd_req === 1'b1) rdCount++;
      if (i == 2) begin
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
      end
      tick();
    end
    mem_ack = 1'b0; mem_rdata = '0;
    expVal = expQ.pop_front();
    tests++;
    if (rdCount != 3 || mem_rd_req !== 1'b0) begin
      fails++;
      $display("FAIL read_req: high %0d cycles, req now %b required 3 cycles then 0", rdCount, mem_rd_req);
    end
    tests++;
    if (done !== 1'b1 || BusMuxIn_MDR !== expVal) begin
      fails++;
      $display("FAIL read_data: done=%b mdr=%h required done=1 mdr=%h", done, BusMuxIn_MDR, expVal);
    end
    tick();
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL read_done_pulse: done=%b required 0", done);
    end
  endtask

  task automatic test_write();
    int badData = 0;
    loadMdr(32'hCAFEF00D);
    wr_start = 1'b1; MDRin = 1'b1; BusMuxOut = 32'h0;
    tick();
    wr_start = 1'b0;
    expQ.push_back(32'hCAFEF00D);
    for (int i = 0; i < 2; i++) begin
      if (mem_wr_req !== 1'b1 || mem_wdata !== 32'hCAFEF00D) badData++;
      if (i == 1) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0; MDRin = 1'b0;
    expVal = expQ.pop_front();
    tests++;
    if (badData != 0) begin
      fails++;
      $display("FAIL write_hold: %0d bad wait cycles required 0 (wr_req=1, wdata=cafef00d)", badData);
    end
    tests++;
    if (done !== 1'b1 || mem_wdata !== expVal || BusMuxIn_MDR !== expVal || busy !== 1'b0) begin
      fails++;
      $display("FAIL write_done: done=%b wdata=%h mdr=%h busy=%b required done=1 %h %h busy=0",
               done, mem_wdata, BusMuxIn_MDR, busy, expVal, expVal);
    end
    tick();
  endtask

  task automatic test_both_starts();
    rd_start = 1'b1; wr_start = 1'b1;
    tick();
    rd_start = 1'b0; wr_start = 1'b0;
    tests++;
    if (mem_rd_req !== 1'b1 || mem_wr_req !== 1'b0) begin
      fails++;
      $display("FAIL priority: rd_req=%b wr_req=%b required 1 0", mem_rd_req, mem_wr_req);
    end
    wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    tests++;
    if (mem_rd_req !== 1'b1 || mem_wr_req !== 1'b0) begin
      fails++;
      $display("FAIL busy_start: rd_req=%b wr_req=%b required 1 0", mem_rd_req, mem_wr_req);
    end
    mem_ack = 1'b1; mem_rdata = 32'hA5A55A5A;
    expQ.push_back(32'hA5A55A5A);
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    expVal = expQ.pop_front();
    tests++;
    if (done !== 1'b1 || BusMuxIn_MDR !== expVal) begin
      fails++;
      $display("FAIL priority_data: done=%b mdr=%h required done=1 mdr=%h", done, BusMuxIn_MDR, expVal);
    end
    tick();
    tests++;
    if (busy !== 1'b0 || mem_wr_req !== 1'b0) begin
      fails++;
      $display("FAIL no_queue: busy=%b wr_req=%b required 0 0", busy, mem_wr_req);
    end
  endtask

  task automatic test_ack_idle();
    mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    tests++;
    if (BusMuxIn_MDR !== 32'hA5A55A5A || done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_ack: mdr=%h done=%b busy=%b required a5a55a5a 0 0", BusMuxIn_MDR, done, busy);
    end
  endtask

  task automatic test_clear_mid();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tests++;
    if (busy !== 1'b0 || mem_rd_req !== 1'b0 || BusMuxIn_MDR !== 32'h0) begin
      fails++;
      $display("FAIL clear_mid: busy=%b rd_req=%b mdr=%h required 0 0 00000000", busy, mem_rd_req, BusMuxIn_MDR);
    end
    mem_ack = 1'b1; mem_rdata = 32'h77778888;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    tests++;
    if (done !== 1'b0 || BusMuxIn_MDR !== 32'h0) begin
      fails++;
      $display("FAIL clear_ack: done=%b mdr=%h required 0 00000000", done, BusMuxIn_MDR);
    end
  endtask

`ifdef MDR_TIMEOUT_EN
  task automatic test_timeout();
    int rdCount = 0;
    int budget = 0;
    loadMdr(32'h0BADF00D);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    while (busy === 1'b1 && budget < 20) begin
      if (mem_rd_req === 1'b1) rdCount++;
      if (done === 1'b1) budget = 100;
      budget++;
      tick();
    end
    tests++;
    if (rdCount != 4 || busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_len: rd_req %0d cycles busy=%b required 4 cycles busy=0", rdCount, busy);
    end
    tests++;
    if (timeout_err !== 1'b1 || done !== 1'b0 || BusMuxIn_MDR !== 32'h0BADF00D) begin
      fails++;
      $display("FAIL timeout_abort: err=%b done=%b mdr=%h required 1 0 0badf00d", timeout_err, done, BusMuxIn_MDR);
    end
    wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    tests++;
    if (timeout_err !== 1'b0 || mem_wr_req !== 1'b1) begin
      fails++;
      $display("FAIL timeout_clear: err=%b wr_req=%b required 0 1", timeout_err, mem_wr_req);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    expQ.push_back(32'h0BADF00D);
    expVal = expQ.pop_front();
    tests++;
    if (done !== 1'b1 || timeout_err !== 1'b0 || mem_wdata !== expVal) begin
      fails++;
      $display("FAIL ack_at_expiry: done=%b err=%b wdata=%h required 1 0 %h", done, timeout_err, mem_wdata, expVal);
    end
    tick();
  endtask
`endif

  initial begin
    clear = 1'b0; MDRin = 1'b0; rd_start = 1'b0; wr_start = 1'b0;
    mem_ack = 1'b0; BusMuxOut = '0; mem_rdata = '0;
    tick();
    test_reset();
    test_load();
    test_read();
    test_write();
    test_both_starts();
    test_ack_idle();
    test_clear_mid();
`ifdef MDR_TIMEOUT_EN
    test_timeout();
`endif
    tests++;
    if (expQ.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
